fir_mac_scheduler: RTL and testbench



---
 rtl/fir_mac_scheduler.sv | 107 ++++++++++
 tb/tb_fir_mac_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: owns the tap delay line and coefficient
// register file and walks one shared multiply-accumulate over all taps,
// one tap per clock, emitting one result per accepted sample.
//
// Handshake: a sample is consumed on a rising edge where x_valid && x_ready.
// x_ready is high only while idle, so x_in/x_valid may change freely while
// x_ready is low; nothing is taken and the delay line holds. Results carry
// no backpressure: y_valid is a one-cycle pulse and y_out holds until the
// next result.
module fir_mac_scheduler #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 2,
  parameter int BW_coef = 2,
  parameter int BW_acc  = 6,
  parameter int BW_out  = 6,
  parameter int AW      = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BW_in-1:0]   x_in,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic               coef_we,
  input  logic [AW-1:0]      coef_addr,
  input  logic [BW_coef-1:0] coef_data,
  output logic [BW_out-1:0]  y_out,
  output logic               y_valid,
  output logic               busy
);

  localparam int PW = BW_in + BW_coef;
  localparam logic [AW-1:0] IDX_LAST = AW'(N_TAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                    state_q;
  logic signed [BW_in-1:0]   d_q    [N_TAPS];
  logic signed [BW_coef-1:0] coef_q [N_TAPS];
  logic signed [BW_acc-1:0]  acc_q;
  logic [AW-1:0]             idx_q;
  logic [BW_out-1:0]         y_out_q;
  logic                      y_valid_q;

  logic signed [PW-1:0]      prod_w;
  logic signed [BW_acc-1:0]  acc_d;
  logic                      coef_addr_ok;

  // Current tap product, sign-extended and added into the wrapping accumulator
  always_comb begin
    prod_w = PW'(d_q[idx_q]) * PW'(coef_q[idx_q]);
    acc_d  = acc_q + BW_acc'(prod_w);
  end

  // Out-of-range addresses only exist when N_TAPS is not a power of two
  assign coef_addr_ok = (int'(coef_addr) < N_TAPS);

  assign x_ready = (state_q == IDLE);
  assign busy    = (state_q == MAC);
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

  // Scheduler FSM: accept a sample in IDLE, then one MAC per tap in MAC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        d_q[k]    <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A write landing on the acceptance edge is seen by that sample
          if (coef_we && coef_addr_ok) begin
            coef_q[coef_addr] <= coef_data;
          end
          if (x_valid) begin
            d_q[0] <= x_in;
            for (int k = 1; k < N_TAPS; k++) begin
              d_q[k] <= d_q[k-1];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (idx_q == IDX_LAST) begin
            y_out_q   <= acc_d[BW_acc-1 -: BW_out];
            y_valid_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: directed scenarios plus a random phase, all
// compared against a transaction-level FIR model kept in this file.
module tb_fir_mac_scheduler;

  localparam int N       = 4;
  localparam int BW_in   = 2;
  localparam int BW_coef = 2;
  localparam int BW_acc  = 6;
  localparam int BW_out  = 6;
  localparam int AW      = 2;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset_n;
  logic [BW_in-1:0]   x_in;
  logic               x_valid;
  logic               x_ready;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic [BW_coef-1:0] coef_data;
  logic [BW_out-1:0]  y_out;
  logic               y_valid;
  logic               busy;

  always #5 clk = ~clk;

  fir_mac_scheduler #(
    .N_TAPS(N), .BW_in(BW_in), .BW_coef(BW_coef),
    .BW_acc(BW_acc), .BW_out(BW_out), .AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .y_valid(y_valid), .busy(busy)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Filter behaviour at transaction level: each accepted sample's result is
  // the wrapped dot product of delay line and coefficients, delivered N
  // clocks later; the block refuses samples and writes while a result is due.
  int                  d_m    [N];
  int                  coef_m [N];
  int                  m_left;
  logic                m_yv;
  logic [BW_out-1:0]   m_y;
  logic [BW_out-1:0]   exp_q [$];
  logic [BW_out-1:0]   got_q [$];

  function automatic logic [BW_out-1:0] model_y();
    int s = 0;
    logic [BW_acc-1:0] a;
    for (int k = 0; k < N; k++) s += d_m[k] * coef_m[k];
    a = BW_acc'(s);
    return a[BW_acc-1 -: BW_out];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      d_m[k] = 0;
      coef_m[k] = 0;
    end
    m_left = 0;
    m_yv = 1'b0;
    m_y = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (m_left > 0) begin
      m_left--;
      m_yv = (m_left == 0);
      if (m_left == 0) m_y = exp_q.pop_front();
    end else begin
      m_yv = 1'b0;
      if (coef_we && int'(coef_addr) < N) coef_m[coef_addr] = int'($signed(coef_data));
      if (x_valid) begin
        for (int k = N - 1; k > 0; k--) d_m[k] = d_m[k-1];
        d_m[0] = int'($signed(x_in));
        exp_q.push_back(model_y());
        m_left = N;
      end
    end
  endtask

  task automatic check_outputs();
    chk("x_ready", x_ready, (m_left == 0));
    chk("busy", busy, (m_left != 0));
    chk("y_valid", y_valid, m_yv);
    chk("y_out", y_out, m_y);
    if (y_valid) got_q.push_back(y_out);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, let one rising edge happen, check.
  task automatic step(input logic v, input logic [BW_in-1:0] x,
                      input logic we, input logic [AW-1:0] a, input logic [BW_coef-1:0] dat);
    x_valid = v; x_in = x; coef_we = we; coef_addr = a; coef_data = dat;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [BW_coef-1:0] dat);
    step(1'b0, '0, 1'b1, a, dat);
  endtask

  // One sample, then N clocks; optional write on the acceptance edge and
  // optional writes attempted during every MAC cycle.
  task automatic send_sample(input logic [BW_in-1:0] x, input logic we0,
                             input logic we_busy, input logic [AW-1:0] a,
                             input logic [BW_coef-1:0] dat);
    step(1'b1, x, we0, a, dat);
    repeat (N) step(1'b0, '0, we_busy, a, dat);
  endtask

  task automatic apply_reset_now();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_x_ready", x_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_y_out", y_out, '0);
  endtask

  task automatic expect_last(input string tag, input logic [BW_out-1:0] exp);
    if (got_q.size() == 0) chk({tag, "_missing"}, 32'd0, 32'd1);
    else chk(tag, got_q[got_q.size()-1], exp);
  endtask

  logic [BW_out-1:0] imp_exp [5];

  // ---------------- stimulus ----------------
  initial begin
    x_valid = 0; x_in = '0; coef_we = 0; coef_addr = '0; coef_data = '0;
    reset_n = 1'b0;
    model_reset();
    #12;
    chk("rst0_x_ready", x_ready, 1'b1);
    chk("rst0_y_out", y_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_step();
    idle_step();

    // Impulse response through coefficients 1,-1,1,-2
    write_coef(2'd0, 2'b01);
    write_coef(2'd1, 2'b11);
    write_coef(2'd2, 2'b01);
    write_coef(2'd3, 2'b10);
    got_q.delete();
    send_sample(2'b01, 0, 0, '0, '0);
    repeat (4) send_sample(2'b00, 0, 0, '0, '0);
    imp_exp[0] = 6'd1; imp_exp[1] = 6'h3f; imp_exp[2] = 6'd1;
    imp_exp[3] = 6'h3e; imp_exp[4] = 6'd0;
    chk("imp_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("imp_y", got_q[i], imp_exp[i]);

    // Extremes: (-2)*(-2) on every tap = 16
    for (int a = 0; a < N; a++) write_coef(AW'(a), 2'b10);
    got_q.delete();
    repeat (4) send_sample(2'b10, 0, 0, '0, '0);
    expect_last("extreme_y", 6'b010000);

    // Asynchronous reset mid-cycle, then two quiet cycles
    @(posedge clk);
    #2;
    apply_reset_now();
    @(negedge clk);
    reset_n = 1'b1;
    idle_step();
    idle_step();

    // Write gating: writes while busy are dropped, write at acceptance applies
    write_coef(2'd0, 2'b01);
    got_q.delete();
    send_sample(2'b01, 0, 1, 2'd0, 2'b11);
    expect_last("gate_busy_y", 6'd1);
    send_sample(2'b01, 1, 0, 2'd0, 2'b11);
    expect_last("gate_e0_y", 6'h3f);

    // Backpressure: x_valid held high, x_in changing every cycle
    for (int i = 0; i < 30; i++) step(1'b1, BW_in'(i), 1'b0, '0, '0);
    repeat (N) idle_step();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(1) == 1, BW_in'($urandom), $urandom_range(3) == 0,
           AW'($urandom_range(N - 1)), BW_coef'($urandom));
    repeat (N + 1) idle_step();

    // Reset during MAC cycle 2 aborts the sample and clears coefficients
    write_coef(2'd0, 2'b01);
    step(1'b1, 2'b01, 1'b0, '0, '0);
    idle_step();
    #2;
    got_q.delete();
    apply_reset_now();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs();
    repeat (N) idle_step();
    chk("abort_no_result", got_q.size(), 0);
    send_sample(2'b01, 0, 0, '0, '0);
    expect_last("coef_cleared_y", 6'd0);
    #2;
    apply_reset_now();
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < N; a++) write_coef(AW'(a), 2'b01);
    send_sample(2'b01, 0, 0, '0, '0);
    expect_last("reload_y", 6'd1);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
